// File: rtl/temp_limit_encoder.sv
// Encodes a signed BCD Celsius limit (quarter-degree resolution) into the
// MCP9808 alert-limit register byte pair via sequential reverse Double Dabble.
module temp_limit_encoder #(
    parameter int MAX_C = 125,
    parameter int MIN_C = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        neg,
    input  logic [11:0] bcd_int,
    input  logic [1:0]  frac_q,
    output logic [7:0]  upper,
    output logic [7:0]  lower,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [11:0] MAX_LIM = 12'(MAX_C);
    localparam logic [11:0] MIN_LIM = 12'(MIN_C);
    localparam logic [7:0]  MAX_MAG = 8'(MAX_C);
    localparam logic [7:0]  MIN_MAG = 8'(MIN_C);

    typedef enum logic [1:0] {IDLE, CHECK, CONVERT, FORMAT} state_t;

    state_t      state, state_n;
    logic        neg_r, neg_n;
    logic [1:0]  frac_r, frac_n;
    logic [11:0] bcd_r, bcd_n;
    logic [23:0] sr, sr_n;
    logic [3:0]  cnt, cnt_n;
    logic [7:0]  upper_n, lower_n;
    logic        busy_n, done_n, err_n;

    logic [23:0] shifted;
    logic        bad_digit;
    logic [11:0] bin;
    logic        sat;
    logic [7:0]  mag;
    logic [1:0]  fq;
    logic [9:0]  q;
    logic [10:0] raw;

    // One reverse Double Dabble step: shift right, then correct BCD nibbles >= 8.
    always_comb begin
        shifted = sr >> 1;
        for (int unsigned i = 0; i < 3; i++) begin
            if (shifted[12 + 4*i +: 4] >= 4'd8)
                shifted[12 + 4*i +: 4] = shifted[12 + 4*i +: 4] - 4'd3;
        end
    end

    assign bad_digit = (bcd_r[11:8] > 4'd9) || (bcd_r[7:4] > 4'd9) || (bcd_r[3:0] > 4'd9);

    // Range check uses the full 12-bit result so 256..999 still saturate.
    always_comb begin
        bin = sr[11:0];
        sat = neg_r ? (bin > MIN_LIM) : (bin > MAX_LIM);
        mag = bin[7:0];
        fq  = frac_r;
        if (sat) begin
            mag = neg_r ? MIN_MAG : MAX_MAG;
            fq  = 2'b00;
        end
        q   = {mag, fq};
        raw = {1'b0, q};
        if (neg_r && (q != '0))
            raw = 11'd0 - {1'b0, q};
    end

    always_comb begin
        state_n = state;
        neg_n   = neg_r;
        frac_n  = frac_r;
        bcd_n   = bcd_r;
        sr_n    = sr;
        cnt_n   = cnt;
        upper_n = upper;
        lower_n = lower;
        busy_n  = busy;
        done_n  = 1'b0;
        err_n   = err;
        case (state)
            IDLE: begin
                if (start) begin
                    neg_n   = neg;
                    bcd_n   = bcd_int;
                    frac_n  = frac_q;
                    err_n   = 1'b0;
                    busy_n  = 1'b1;
                    state_n = CHECK;
                end
            end
            CHECK: begin
                if (bad_digit) begin
                    err_n   = 1'b1;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    sr_n    = {bcd_r, 12'h000};
                    cnt_n   = '0;
                    state_n = CONVERT;
                end
            end
            CONVERT: begin
                sr_n  = shifted;
                cnt_n = cnt + 4'd1;
                if (cnt == 4'd11)
                    state_n = FORMAT;
            end
            FORMAT: begin
                upper_n = {3'b000, raw[10], raw[9:6]};
                lower_n = {raw[5:0], 2'b00};
                err_n   = sat;
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            neg_r  <= 1'b0;
            frac_r <= '0;
            bcd_r  <= '0;
            sr     <= '0;
            cnt    <= '0;
            upper  <= '0;
            lower  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            neg_r  <= neg_n;
            frac_r <= frac_n;
            bcd_r  <= bcd_n;
            sr     <= sr_n;
            cnt    <= cnt_n;
            upper  <= upper_n;
            lower  <= lower_n;
            busy   <= busy_n;
            done   <= done_n;
            err    <= err_n;
        end
    end

endmodule

// File: tb/tb_temp_limit_encoder.sv
// Directed plus randomized checks of temp_limit_encoder against an
// arithmetic model of signed quarter-degree limit encoding.
module tb_temp_limit_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        neg;
    logic [11:0] bcd_int;
    logic [1:0]  frac_q;
    logic [7:0]  upper;
    logic [7:0]  lower;
    logic        busy;
    logic        done;
    logic        err;

    temp_limit_encoder #(.MAX_C(125), .MIN_C(40)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .neg     (neg),
        .bcd_int (bcd_int),
        .frac_q  (frac_q),
        .upper   (upper),
        .lower   (lower),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #10 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_upper = 8'h00;
    logic [7:0] exp_lower = 8'h00;
    logic       exp_err = 1'b0;
    int         exp_lat = 14;
    int         lat, lat2, pulses;
    logic [3:0] d2, d1, d0;
    logic       rn;
    logic [1:0] rf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Signed Celsius -> clamp -> quarter count -> 13-bit two's complement of value*16.
    task automatic model(input logic n, input logic [11:0] b, input logic [1:0] f);
        int h, t, o, val, lim, fr, qq, rw;
        h = int'(b[11:8]);
        t = int'(b[7:4]);
        o = int'(b[3:0]);
        if (h > 9 || t > 9 || o > 9) begin
            exp_err = 1'b1;
            exp_lat = 1;
            return;
        end
        exp_lat = 14;
        val = h * 100 + t * 10 + o;
        lim = n ? 40 : 125;
        fr  = int'(f);
        exp_err = (val > lim);
        if (val > lim) begin
            val = lim;
            fr  = 0;
        end
        qq = val * 4 + fr;
        rw = (n ? -qq : qq) * 4;
        exp_upper = 8'((rw >>> 8) & 31);
        exp_lower = 8'(rw & 255);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (done !== 1'b1 && n < 40);
    endtask

    task automatic count_pulses(input int cycles, output int p);
        p = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) p++;
        end
    endtask

    task automatic do_conv(input logic n, input logic [11:0] b, input logic [1:0] f, input string tag);
        int l;
        neg = n;
        bcd_int = b;
        frac_q = f;
        start = 1'b1;
        model(n, b, f);
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, ".busy_hi"}, 32'(busy), 32'd1);
        wait_done(l);
        check({tag, ".latency"}, 32'(l), 32'(exp_lat));
        check({tag, ".upper"}, 32'(upper), 32'(exp_upper));
        check({tag, ".lower"}, 32'(lower), 32'(exp_lower));
        check({tag, ".err"}, 32'(err), 32'(exp_err));
        check({tag, ".busy_lo"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, ".done_1cyc"}, 32'(done), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        neg = 1'b0;
        bcd_int = 12'h000;
        frac_q = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.upper", 32'(upper), 32'h00);
        check("rst.lower", 32'(lower), 32'h00);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        do_conv(1'b0, 12'h025, 2'd0, "p25_00");
        do_conv(1'b1, 12'h010, 2'd1, "m10_25");
        do_conv(1'b0, 12'h125, 2'd3, "p125_75");
        do_conv(1'b0, 12'h130, 2'd2, "sat_pos");
        do_conv(1'b1, 12'h055, 2'd0, "sat_neg");
        do_conv(1'b0, 12'h999, 2'd1, "sat_999");
        do_conv(1'b1, 12'h040, 2'd3, "m40_75");
        do_conv(1'b0, 12'h025, 2'd0, "p25_again");
        do_conv(1'b0, 12'h1A5, 2'd0, "bad_digit");
        do_conv(1'b0, 12'h025, 2'd0, "p25_pre_rst");

        // Asynchronous reset six cycles into CONVERT aborts the conversion.
        neg = 1'b0;
        bcd_int = 12'h099;
        frac_q = 2'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        exp_upper = 8'h00;
        exp_lower = 8'h00;
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        check("midrst.upper", 32'(upper), 32'h00);
        check("midrst.lower", 32'(lower), 32'h00);
        @(negedge clk);
        reset = 1'b1;
        count_pulses(20, pulses);
        check("midrst.no_done", 32'(pulses), 32'd0);
        do_conv(1'b0, 12'h099, 2'd1, "post_rst");

        // Start during busy is ignored; only the first request completes.
        model(1'b0, 12'h042, 2'd2);
        neg = 1'b0;
        bcd_int = 12'h042;
        frac_q = 2'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b1;
        neg = 1'b1;
        bcd_int = 12'h007;
        @(posedge clk);
        #1;
        lat++;
        start = 1'b0;
        wait_done(lat2);
        check("overlap.latency", 32'(lat + lat2), 32'd14);
        check("overlap.upper", 32'(upper), 32'(exp_upper));
        check("overlap.lower", 32'(lower), 32'(exp_lower));
        count_pulses(20, pulses);
        check("overlap.one_done", 32'(pulses), 32'd0);

        // Held start re-triggers right after done.
        model(1'b1, 12'h005, 2'd2);
        neg = 1'b1;
        bcd_int = 12'h005;
        frac_q = 2'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(lat);
        check("held.lat1", 32'(lat), 32'd14);
        check("held.upper1", 32'(upper), 32'(exp_upper));
        wait_done(lat2);
        start = 1'b0;
        check("held.lat2", 32'(lat2), 32'd15);
        check("held.lower2", 32'(lower), 32'(exp_lower));
        @(posedge clk);
        #1;
        check("held.idle", 32'(busy), 32'd0);

        do_conv(1'b1, 12'h000, 2'd0, "neg_zero");

        for (int i = 0; i < 40; i++) begin
            d2 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 1));
            d1 = 4'($urandom_range(0, 9));
            d0 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            rn = 1'($urandom_range(0, 1));
            rf = 2'($urandom_range(0, 3));
            do_conv(rn, {d2, d1, d0}, rf, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
